// File: rtl/image_sensor_emulator.sv
// On-chip pixel source: on an accepted capture, streams one NUM_PIXELS frame from a selectable pattern, then pulses done.
// First pixel START_DELAY edges after acceptance, one pixel per clock; no backpressure, and captures while busy are dropped.
module image_sensor_emulator #(
    parameter int NUM_PIXELS  = 64,
    parameter int DATA_WIDTH  = 9,
    parameter int START_DELAY = 2
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_enable,
    input  logic                  in_frame_capture,
    input  logic [1:0]            in_mode,
    input  logic [DATA_WIDTH-1:0] in_seed,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_done,
    output logic                  out_busy,
    output logic [7:0]            out_frame_count
);

    localparam int CW = $clog2(NUM_PIXELS);
    localparam logic [CW-1:0] LAST_PIX = CW'(NUM_PIXELS - 1);
    localparam logic [3:0]    DLY_LAST = 4'(START_DELAY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, STREAM, DONE} state_t;

    state_t                  state;
    logic [3:0]              dly_cnt;
    logic [CW-1:0]           pix_idx;
    logic [1:0]              mode_q;
    logic [DATA_WIDTH-1:0]   seed_q;
    logic [DATA_WIDTH-1:0]   lfsr;

    logic [CW-1:0]           nxt_idx;
    logic [DATA_WIDTH-1:0]   nxt_pix;
    logic [DATA_WIDTH-1:0]   lfsr_adv;

    // nxt_pix is the pixel to be registered at the coming edge; index 0 while leaving WAIT.
    always_comb begin
        nxt_idx  = (state == STREAM) ? pix_idx + 1'b1 : '0;
        lfsr_adv = {lfsr[DATA_WIDTH-2:0], lfsr[8] ^ lfsr[4]};
        nxt_pix  = seed_q;
        case (mode_q)
            2'b00:   nxt_pix = seed_q + DATA_WIDTH'(nxt_idx);
            2'b01:   nxt_pix = (nxt_idx[3] ^ nxt_idx[0]) ? seed_q : ~seed_q;
            2'b10:   nxt_pix = lfsr;
            default: nxt_pix = seed_q;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state           <= IDLE;
            dly_cnt         <= '0;
            pix_idx         <= '0;
            mode_q          <= '0;
            seed_q          <= '0;
            lfsr            <= '0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            out_done        <= 1'b0;
            out_busy        <= 1'b0;
            out_frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_frame_capture && in_enable) begin
                        state    <= WAIT;
                        out_busy <= 1'b1;
                        mode_q   <= in_mode;
                        seed_q   <= in_seed;
                        lfsr     <= (in_seed == '0) ? '1 : in_seed;
                        dly_cnt  <= '0;
                    end
                end
                WAIT: begin
                    if (dly_cnt == DLY_LAST) begin
                        state     <= STREAM;
                        out_data  <= nxt_pix;
                        out_valid <= 1'b1;
                        pix_idx   <= '0;
                        lfsr      <= lfsr_adv;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (pix_idx == LAST_PIX) begin
                        state           <= DONE;
                        out_data        <= '0;
                        out_valid       <= 1'b0;
                        out_done        <= 1'b1;
                        out_frame_count <= out_frame_count + 1'b1;
                    end else begin
                        out_data <= nxt_pix;
                        pix_idx  <= nxt_idx;
                        lfsr     <= lfsr_adv;
                    end
                end
                DONE: begin
                    // Capture is only sampled in IDLE, so a held request restarts one edge later.
                    state    <= IDLE;
                    out_done <= 1'b0;
                    out_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_sensor_emulator.sv
// Directed scenario sequence with randomized pattern/seed, checked every cycle against a frame-timeline model.
module tb_image_sensor_emulator;
    localparam int NP = 64;
    localparam int DW = 9;
    localparam int SD = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          cap;
    logic [1:0]    mode;
    logic [DW-1:0] seed;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_done;
    logic          out_busy;
    logic [7:0]    out_frame_count;

    always #5 clk = ~clk;

    image_sensor_emulator #(.NUM_PIXELS(NP), .DATA_WIDTH(DW), .START_DELAY(SD)) dut (
        .in_clk(clk), .in_rst(rst_n), .in_enable(enable), .in_frame_capture(cap),
        .in_mode(mode), .in_seed(seed), .out_data(out_data), .out_valid(out_valid),
        .out_done(out_done), .out_busy(out_busy), .out_frame_count(out_frame_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // Timeline model: a frame accepted at edge t0 is described purely by the offset t - t0.
    bit            m_active = 1'b0;
    int            m_t0 = 0;
    int            t = 0;
    logic [7:0]    m_cnt = 8'd0;
    logic [DW-1:0] m_frame [NP];
    logic [DW-1:0] obs_pix [NP];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void build_frame(input logic [1:0] md, input logic [DW-1:0] sd);
        logic [DW-1:0] s;
        s = (sd == '0) ? 9'h1FF : sd;
        for (int k = 0; k < NP; k++) begin
            case (md)
                2'd0: m_frame[k] = sd + 9'(k);
                2'd1: m_frame[k] = ((((k / 8) + k) % 2) == 1) ? sd : ~sd;
                2'd2: begin
                    m_frame[k] = s;
                    s = {s[7:0], s[8] ^ s[4]};
                end
                default: m_frame[k] = sd;
            endcase
        end
    endfunction

    task automatic tick();
        int o;
        logic e_busy, e_valid, e_done;
        logic [DW-1:0] e_data;
        @(posedge clk);
        t++;
        if (!rst_n) begin
            m_active = 1'b0;
            m_cnt    = 8'd0;
        end else if (!m_active) begin
            if (cap && enable) begin
                m_active = 1'b1;
                m_t0     = t;
                build_frame(mode, seed);
            end
        end else begin
            o = t - m_t0;
            if (o == SD + NP) m_cnt++;
            else if (o == SD + NP + 1) m_active = 1'b0;
        end
        o       = t - m_t0;
        e_busy  = m_active;
        e_valid = m_active && o >= SD && o < SD + NP;
        e_done  = m_active && o == SD + NP;
        e_data  = e_valid ? m_frame[o - SD] : '0;
        #1;
        check("busy",  32'(out_busy),        32'(e_busy));
        check("valid", 32'(out_valid),       32'(e_valid));
        check("done",  32'(out_done),        32'(e_done));
        check("data",  32'(out_data),        32'(e_data));
        check("count", 32'(out_frame_count), 32'(m_cnt));
        if (e_valid) obs_pix[o - SD] = out_data;
    endtask

    task automatic scramble();
        mode = 2'($urandom_range(0, 3));
        seed = 9'($urandom_range(0, 511));
    endtask

    task automatic run_frame(input logic [1:0] md, input logic [DW-1:0] sd);
        mode = md; seed = sd; cap = 1'b1; enable = 1'b1;
        tick();
        cap = 1'b0;
        for (int j = 0; j < SD + NP + 1; j++) begin
            scramble();
            tick();
        end
    endtask

    logic [7:0] cnt_before;

    initial begin
        rst_n = 1'b0; enable = 1'b0; cap = 1'b0; mode = 2'd0; seed = '0;
        tick(); tick();
        check("rst_data",  32'(out_data),        32'd0);
        check("rst_count", 32'(out_frame_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Ramp with wrap at 512.
        run_frame(2'd0, 9'd500);
        check("ramp_p0",  32'(obs_pix[0]),  32'd500);
        check("ramp_p11", 32'(obs_pix[11]), 32'd511);
        check("ramp_p12", 32'(obs_pix[12]), 32'd0);
        check("ramp_p63", 32'(obs_pix[63]), 32'd51);
        check("ramp_cnt", 32'(out_frame_count), 32'd1);

        run_frame(2'd1, 9'h0F0);
        check("chk_p0", 32'(obs_pix[0]), 32'h10F);
        check("chk_p1", 32'(obs_pix[1]), 32'h0F0);
        check("chk_p8", 32'(obs_pix[8]), 32'h0F0);
        check("chk_p9", 32'(obs_pix[9]), 32'h10F);

        run_frame(2'd2, 9'd1);
        check("lfsr_p0", 32'(obs_pix[0]), 32'h001);
        check("lfsr_p3", 32'(obs_pix[3]), 32'h008);
        check("lfsr_p4", 32'(obs_pix[4]), 32'h010);
        check("lfsr_p5", 32'(obs_pix[5]), 32'h021);
        run_frame(2'd2, 9'd0);
        check("lfsr0_p0", 32'(obs_pix[0]), 32'h1FF);

        run_frame(2'd3, 9'($urandom_range(0, 511)));
        check("const_eq", 32'(obs_pix[40]), 32'(obs_pix[7]));

        // Captures during WAIT, mid-STREAM and in the DONE cycle must all be dropped.
        cnt_before = out_frame_count;
        mode = 2'd0; seed = 9'($urandom_range(0, 511)); cap = 1'b1;
        tick();
        for (int j = 1; j <= SD + NP + 3; j++) begin
            cap = (j == 1 || j == SD + 30 || j == SD + NP + 1);
            scramble();
            tick();
        end
        check("ignore_busy", 32'(out_busy), 32'd0);
        check("ignore_cnt",  32'(out_frame_count), 32'(8'(cnt_before + 8'd1)));

        // Capture held for 200 cycles: frames start at 0, 68 and 136.
        cnt_before = out_frame_count;
        cap = 1'b1;
        for (int j = 0; j < 200; j++) begin
            scramble();
            tick();
        end
        cap = 1'b0;
        for (int j = 0; j < 80; j++) tick();
        check("held_frames", 32'(8'(out_frame_count - cnt_before)), 32'd3);

        // Reset while pixel 30 is on the output.
        mode = 2'd0; seed = 9'd7; cap = 1'b1;
        tick();
        cap = 1'b0;
        for (int j = 0; j < SD + 30; j++) tick();
        check("pre_rst_pix", 32'(out_data), 32'd37);
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy",  32'(out_busy),        32'd0);
        check("mid_rst_count", 32'(out_frame_count), 32'd0);
        rst_n = 1'b1;
        tick();
        run_frame(2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
        check("post_rst_cnt", 32'(out_frame_count), 32'd1);

        // Enable low blocks capture in IDLE.
        enable = 1'b0; cap = 1'b1;
        tick(); tick(); tick();
        check("en_block_busy", 32'(out_busy), 32'd0);
        cap = 1'b0; enable = 1'b1;

        // Enable dropped at pixel 10: frame still completes.
        cnt_before = out_frame_count;
        mode = 2'($urandom_range(0, 3)); seed = 9'($urandom_range(0, 511)); cap = 1'b1;
        tick();
        cap = 1'b0;
        for (int j = 1; j <= SD + NP + 1; j++) begin
            enable = (j <= SD + 10);
            tick();
        end
        enable = 1'b1;
        check("en_drop_cnt", 32'(out_frame_count), 32'(8'(cnt_before + 8'd1)));

        // Frame counter wrap 255 -> 0.
        for (int f = 0; f < 300 && out_frame_count != 8'd255; f++)
            run_frame(2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
        check("wrap_255", 32'(out_frame_count), 32'd255);
        run_frame(2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
        check("wrap_0", 32'(out_frame_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
